// File: rtl/fir_mac_scheduler.sv
// Shared signed MAC for several FIR requesters: round-robin grant, TAPS-long
// coefficient/sample fetch, wide accumulation and a dequantized result handshake.
module fir_mac_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TAPS    = 32,
    parameter int DATA_W  = 32,
    parameter int BITS    = 10,
    localparam int ID_W   = $clog2(NUM_REQ),
    localparam int ADDR_W = $clog2(TAPS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    output logic                rd_en,
    output logic [ID_W-1:0]     rd_sel,
    output logic [ADDR_W-1:0]   tap_idx,
    input  logic [DATA_W-1:0]   coef_data,
    input  logic [DATA_W-1:0]   samp_data,
    output logic                res_valid,
    output logic [DATA_W-1:0]   res_data,
    output logic [ID_W-1:0]     res_id,
    input  logic                res_ready,
    output logic                busy
);

    localparam int ACC_W = 2*DATA_W + ADDR_W + 1;
    localparam int ROUND = (1 << BITS) - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_FETCH,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t                    r_state;
    state_t                    w_nextState;
    logic [ID_W-1:0]           r_ptr;
    logic [NUM_REQ-1:0]        r_reqReady;
    logic                      r_rdEn;
    logic [ID_W-1:0]           r_rdSel;
    logic [ADDR_W-1:0]         r_tapIdx;
    logic                      r_accEn;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_resValid;
    logic [DATA_W-1:0]         r_resData;
    logic [ID_W-1:0]           r_resId;

    logic                      w_found;
    logic [ID_W-1:0]           w_pick;
    logic [ID_W-1:0]           w_idx;
    logic                      w_grant;
    logic [NUM_REQ-1:0]        w_reqReadyNext;
    logic                      w_rdEnNext;
    logic [ADDR_W-1:0]         w_tapNext;
    logic                      w_resLoad;
    logic                      w_resAccept;

    logic signed [2*DATA_W-1:0] w_coefExt;
    logic signed [2*DATA_W-1:0] w_sampExt;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prodExt;
    logic signed [ACC_W-1:0]    w_accSum;
    logic signed [ACC_W-1:0]    w_rounded;
    logic [DATA_W-1:0]          w_resData;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_nextState = S_GRANT;
            S_GRANT: w_nextState = S_FETCH;
            S_FETCH: if (r_tapIdx == ADDR_W'(TAPS-1)) w_nextState = S_DRAIN;
            S_DRAIN: w_nextState = S_OUT;
            S_OUT:   if (r_resValid && res_ready) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Next values for the registered outputs, derived from the current and next state.
    always_comb begin
        w_grant        = (r_state == S_IDLE) && w_found;
        w_reqReadyNext = w_grant ? (NUM_REQ'(1) << w_pick) : '0;
        w_rdEnNext     = (w_nextState == S_FETCH);
        w_tapNext      = '0;
        if (r_state == S_FETCH && r_tapIdx != ADDR_W'(TAPS-1)) begin
            w_tapNext = r_tapIdx + ADDR_W'(1);
        end
        w_resLoad      = (r_state == S_DRAIN);
        w_resAccept    = (r_state == S_OUT) && r_resValid && res_ready;
    end

    // Product is sign-extended into an accumulator wide enough for TAPS full-scale terms.
    always_comb begin
        w_coefExt = {{DATA_W{coef_data[DATA_W-1]}}, coef_data};
        w_sampExt = {{DATA_W{samp_data[DATA_W-1]}}, samp_data};
        w_prod    = w_coefExt * w_sampExt;
        w_prodExt = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
        w_accSum  = r_acc + (r_accEn ? w_prodExt : '0);
        w_rounded = w_accSum[ACC_W-1] ? (w_accSum + ACC_W'(ROUND)) : w_accSum;
        w_resData = DATA_W'(w_rounded >>> BITS);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr      <= ID_W'(NUM_REQ-1);
            r_reqReady <= '0;
            r_rdEn     <= 1'b0;
            r_rdSel    <= '0;
            r_tapIdx   <= '0;
            r_accEn    <= 1'b0;
            r_acc      <= '0;
            r_resValid <= 1'b0;
            r_resData  <= '0;
            r_resId    <= '0;
        end else begin
            r_reqReady <= w_reqReadyNext;
            r_rdEn     <= w_rdEnNext;
            r_tapIdx   <= w_tapNext;
            r_accEn    <= r_rdEn;
            if (w_grant) begin
                r_rdSel <= w_pick;
                r_ptr   <= w_pick;
            end
            if (r_state == S_GRANT) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_accSum;
            end
            if (w_resLoad) begin
                r_resValid <= 1'b1;
                r_resData  <= w_resData;
                r_resId    <= r_rdSel;
            end else if (w_resAccept) begin
                r_resValid <= 1'b0;
            end
        end
    end

    assign req_ready = r_reqReady;
    assign rd_en     = r_rdEn;
    assign rd_sel    = r_rdSel;
    assign tap_idx   = r_tapIdx;
    assign res_valid = r_resValid;
    assign res_data  = r_resData;
    assign res_id    = r_resId;
    assign busy      = (r_state != S_IDLE);

endmodule
